// File: rtl/triangle_setup.sv
// Triangle setup: collects three vertices from a non-FWFT FIFO, forms edge
// differences, doubled area and a clamped bbox, culls, and hands CCW triangles
// to the rasterizer. Macro CULL_BACKFACE_EN culls clockwise triangles instead
// of reordering them.
module triangle_setup #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int COORD_W  = 12
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_fifo_empty,
  output logic                   o_fifo_rd_en,
  input  logic [31:0]            i_vtx_x,
  input  logic [31:0]            i_vtx_y,
  input  logic [7:0]             i_vtx_z,
  input  logic [31:0]            i_vtx_u,
  input  logic [31:0]            i_vtx_v,
  input  logic                   i_flush,
  output logic                   o_tri_valid,
  input  logic                   i_tri_ready,
  output logic [3*COORD_W-1:0]   o_tri_x,
  output logic [3*COORD_W-1:0]   o_tri_y,
  output logic [23:0]            o_tri_z,
  output logic [95:0]            o_tri_u,
  output logic [95:0]            o_tri_v,
  output logic [2*COORD_W+2:0]   o_tri_area,
  output logic [COORD_W-1:0]     o_bbox_xmin,
  output logic [COORD_W-1:0]     o_bbox_xmax,
  output logic [COORD_W-1:0]     o_bbox_ymin,
  output logic [COORD_W-1:0]     o_bbox_ymax,
  output logic [15:0]            o_culled_count,
  output logic [2:0]             o_dbg_state
);

  localparam int DW = COORD_W + 1;
  localparam int AW = 2 * COORD_W + 3;
  localparam logic signed [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
  localparam logic signed [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DIFF   = 3'd1,
    S_AREA   = 3'd2,
    S_DECIDE = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t state;
  logic [1:0] iss_cnt;
  logic [1:0] cap_cnt;
  logic       rd_pend;

  logic signed [COORD_W-1:0] sx [3];
  logic signed [COORD_W-1:0] sy [3];
  logic [7:0]                sz [3];
  logic [31:0]               su [3];
  logic [31:0]               sv [3];

  logic signed [DW-1:0]      dx1, dy1, dx2, dy2;
  logic signed [AW-1:0]      area_r;
  logic signed [COORD_W-1:0] xmin_r, xmax_r, ymin_r, ymax_r;
  logic signed [COORD_W-1:0] xmin_c, xmax_c, ymin_c, ymax_c;
  logic                      off_screen, cull, swap;
  logic [COORD_W-1:0]        cap_x, cap_y;
  logic                      unused_vtx_bits;

  function automatic logic signed [DW-1:0] ext_d(input logic signed [COORD_W-1:0] a);
    return {a[COORD_W-1], a};
  endfunction

  function automatic logic signed [AW-1:0] ext_a(input logic signed [DW-1:0] a);
    return {{(AW-DW){a[DW-1]}}, a};
  endfunction

  function automatic logic signed [COORD_W-1:0] min3(input logic signed [COORD_W-1:0] a,
                                                     input logic signed [COORD_W-1:0] b,
                                                     input logic signed [COORD_W-1:0] c);
    logic signed [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic signed [COORD_W-1:0] max3(input logic signed [COORD_W-1:0] a,
                                                     input logic signed [COORD_W-1:0] b,
                                                     input logic signed [COORD_W-1:0] c);
    logic signed [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Taking the integer field of Q16.16 directly is a floor, also for negatives.
  assign cap_x = i_vtx_x[16 +: COORD_W];
  assign cap_y = i_vtx_y[16 +: COORD_W];
  assign unused_vtx_bits = ^{i_vtx_x[31:16+COORD_W], i_vtx_x[15:0],
                             i_vtx_y[31:16+COORD_W], i_vtx_y[15:0]};

  // Non-FWFT FIFO: data arrives the cycle after the strobe; at most three reads per triangle.
  assign o_fifo_rd_en = (state == S_FETCH) && !i_fifo_empty && (iss_cnt != 2'd3) &&
                        !i_flush && !i_rst;
  assign o_dbg_state  = state;

  always_comb begin
    off_screen = xmax_r[COORD_W-1] || (xmin_r > X_LIM) ||
                 ymax_r[COORD_W-1] || (ymin_r > Y_LIM);
`ifdef CULL_BACKFACE_EN
    cull = (area_r == '0) || off_screen || area_r[AW-1];
    swap = 1'b0;
`else
    cull = (area_r == '0) || off_screen;
    swap = area_r[AW-1];
`endif
    xmin_c = xmin_r[COORD_W-1] ? '0 : xmin_r;
    ymin_c = ymin_r[COORD_W-1] ? '0 : ymin_r;
    xmax_c = (xmax_r > X_LIM) ? X_LIM : xmax_r;
    ymax_c = (ymax_r > Y_LIM) ? Y_LIM : ymax_r;
  end

  // Output handshake: a triangle is presented with o_tri_valid=1 and every o_tri_*/o_bbox_*
  // held constant until the cycle where o_tri_valid && i_tri_ready, which is the transfer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= S_FETCH;
      iss_cnt        <= '0;
      cap_cnt        <= '0;
      rd_pend        <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        sx[i] <= '0;
        sy[i] <= '0;
        sz[i] <= '0;
        su[i] <= '0;
        sv[i] <= '0;
      end
      dx1            <= '0;
      dy1            <= '0;
      dx2            <= '0;
      dy2            <= '0;
      area_r         <= '0;
      xmin_r         <= '0;
      xmax_r         <= '0;
      ymin_r         <= '0;
      ymax_r         <= '0;
      o_tri_valid    <= 1'b0;
      o_tri_x        <= '0;
      o_tri_y        <= '0;
      o_tri_z        <= '0;
      o_tri_u        <= '0;
      o_tri_v        <= '0;
      o_tri_area     <= '0;
      o_bbox_xmin    <= '0;
      o_bbox_xmax    <= '0;
      o_bbox_ymin    <= '0;
      o_bbox_ymax    <= '0;
      o_culled_count <= '0;
    end else begin
      rd_pend <= o_fifo_rd_en;
      case (state)
        S_FETCH: begin
          if (i_flush) begin
            iss_cnt <= '0;
            cap_cnt <= '0;
          end else begin
            if (o_fifo_rd_en) iss_cnt <= iss_cnt + 2'd1;
            if (rd_pend) begin
              for (int i = 0; i < 3; i++) begin
                if (cap_cnt == 2'(i)) begin
                  sx[i] <= cap_x;
                  sy[i] <= cap_y;
                  sz[i] <= i_vtx_z;
                  su[i] <= i_vtx_u;
                  sv[i] <= i_vtx_v;
                end
              end
              if (cap_cnt == 2'd2) begin
                cap_cnt <= '0;
                iss_cnt <= '0;
                state   <= S_DIFF;
              end else begin
                cap_cnt <= cap_cnt + 2'd1;
              end
            end
          end
        end
        S_DIFF: begin
          dx1   <= ext_d(sx[1]) - ext_d(sx[0]);
          dy1   <= ext_d(sy[1]) - ext_d(sy[0]);
          dx2   <= ext_d(sx[2]) - ext_d(sx[0]);
          dy2   <= ext_d(sy[2]) - ext_d(sy[0]);
          state <= S_AREA;
        end
        S_AREA: begin
          area_r <= ext_a(dx1) * ext_a(dy2) - ext_a(dx2) * ext_a(dy1);
          xmin_r <= min3(sx[0], sx[1], sx[2]);
          xmax_r <= max3(sx[0], sx[1], sx[2]);
          ymin_r <= min3(sy[0], sy[1], sy[2]);
          ymax_r <= max3(sy[0], sy[1], sy[2]);
          state  <= S_DECIDE;
        end
        S_DECIDE: begin
          if (cull) begin
            if (o_culled_count != 16'hFFFF) o_culled_count <= o_culled_count + 16'd1;
            state <= S_FETCH;
          end else begin
            // Swapping slots 1 and 2 flips the winding, so the area changes sign with it.
            o_tri_x     <= swap ? {sx[1], sx[2], sx[0]} : {sx[2], sx[1], sx[0]};
            o_tri_y     <= swap ? {sy[1], sy[2], sy[0]} : {sy[2], sy[1], sy[0]};
            o_tri_z     <= swap ? {sz[1], sz[2], sz[0]} : {sz[2], sz[1], sz[0]};
            o_tri_u     <= swap ? {su[1], su[2], su[0]} : {su[2], su[1], su[0]};
            o_tri_v     <= swap ? {sv[1], sv[2], sv[0]} : {sv[2], sv[1], sv[0]};
            o_tri_area  <= swap ? -area_r : area_r;
            o_bbox_xmin <= xmin_c;
            o_bbox_xmax <= xmax_c;
            o_bbox_ymin <= ymin_c;
            o_bbox_ymax <= ymax_c;
            o_tri_valid <= 1'b1;
            state       <= S_OUT;
          end
        end
        S_OUT: begin
          if (i_tri_ready) begin
            o_tri_valid <= 1'b0;
            state       <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_setup.sv
// Directed bench for triangle_setup: vector table of triangles with hand-computed
// results, plus hold/resume, flush and async-reset sequences.
module tb_triangle_setup;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_DIFF  = 3'd1;
  localparam logic [2:0] ST_OUT   = 3'd4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_fifo_empty;
  logic        o_fifo_rd_en;
  logic [31:0] vtx_x, vtx_y, vtx_u, vtx_v;
  logic [7:0]  vtx_z;
  logic        i_flush;
  logic        o_tri_valid;
  logic        i_tri_ready;
  logic [35:0] o_tri_x, o_tri_y;
  logic [23:0] o_tri_z;
  logic [95:0] o_tri_u, o_tri_v;
  logic [26:0] o_tri_area;
  logic [11:0] o_bbox_xmin, o_bbox_xmax, o_bbox_ymin, o_bbox_ymax;
  logic [15:0] o_culled_count;
  logic [2:0]  o_dbg_state;

  triangle_setup dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_fifo_empty(i_fifo_empty), .o_fifo_rd_en(o_fifo_rd_en),
    .i_vtx_x(vtx_x), .i_vtx_y(vtx_y), .i_vtx_z(vtx_z), .i_vtx_u(vtx_u), .i_vtx_v(vtx_v),
    .i_flush(i_flush), .o_tri_valid(o_tri_valid), .i_tri_ready(i_tri_ready),
    .o_tri_x(o_tri_x), .o_tri_y(o_tri_y), .o_tri_z(o_tri_z), .o_tri_u(o_tri_u),
    .o_tri_v(o_tri_v), .o_tri_area(o_tri_area), .o_bbox_xmin(o_bbox_xmin),
    .o_bbox_xmax(o_bbox_xmax), .o_bbox_ymin(o_bbox_ymin), .o_bbox_ymax(o_bbox_ymax),
    .o_culled_count(o_culled_count), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  // non-FWFT FIFO model: data appears the cycle after rd_en
  logic [31:0] mx [128];
  logic [31:0] my [128];
  logic [31:0] mu [128];
  logic [31:0] mv [128];
  logic [7:0]  mz [128];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign i_fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge i_clk) begin
    if (o_fifo_rd_en) begin
      vtx_x  <= mx[rd_ptr];
      vtx_y  <= my[rd_ptr];
      vtx_z  <= mz[rd_ptr];
      vtx_u  <= mu[rd_ptr];
      vtx_v  <= mv[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  typedef struct {
    logic [95:0] vx, vy, vu, vv;
    logic [23:0] vz;
    logic        cull;
    logic [35:0] ex, ey;
    logic [23:0] ez;
    logic [95:0] eu, ev;
    logic [26:0] earea;
    logic [11:0] exmin, exmax, eymin, eymax;
  } vec_t;

  vec_t vecs [6];
  int n_chk = 0;
  int n_fail = 0;
  int exp_culled = 0;

  function automatic logic [31:0] q(input int i);
    return 32'(i) << 16;
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // driver tasks
  task automatic push_one(input vec_t t, input int k);
    mx[wr_ptr] = t.vx[k*32 +: 32];
    my[wr_ptr] = t.vy[k*32 +: 32];
    mz[wr_ptr] = t.vz[k*8 +: 8];
    mu[wr_ptr] = t.vu[k*32 +: 32];
    mv[wr_ptr] = t.vv[k*32 +: 32];
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_vec(input vec_t t);
    for (int k = 0; k < 3; k++) push_one(t, k);
  endtask

  task automatic expect_out(input vec_t t, input string tag);
    bit ok;
    int lat;
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge i_clk);
      if (o_dbg_state == ST_DIFF) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_timeout({tag, "_collect"});
      return;
    end
    lat = 0;
    while (!o_tri_valid && lat < 10) begin
      @(negedge i_clk);
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'd3);
    check({tag, "_x"}, o_tri_x, t.ex);
    check({tag, "_y"}, o_tri_y, t.ey);
    check({tag, "_z"}, o_tri_z, t.ez);
    check({tag, "_u"}, o_tri_u, t.eu);
    check({tag, "_v"}, o_tri_v, t.ev);
    check({tag, "_area"}, o_tri_area, t.earea);
    check({tag, "_xmin"}, o_bbox_xmin, t.exmin);
    check({tag, "_xmax"}, o_bbox_xmax, t.exmax);
    check({tag, "_ymin"}, o_bbox_ymin, t.eymin);
    check({tag, "_ymax"}, o_bbox_ymax, t.eymax);
    check({tag, "_culled"}, o_culled_count, 128'(exp_culled));
  endtask

  task automatic transfer(input string tag);
    i_tri_ready = 1'b1;
    @(negedge i_clk);
    i_tri_ready = 1'b0;
    check({tag, "_valid_drop"}, o_tri_valid, 1'b0);
  endtask

  task automatic expect_cull(input string tag);
    bit saw;
    saw = 1'b0;
    repeat (25) begin
      @(negedge i_clk);
      if (o_tri_valid) saw = 1'b1;
    end
    exp_culled++;
    check({tag, "_no_valid"}, saw, 1'b0);
    check({tag, "_culled"}, o_culled_count, 128'(exp_culled));
  endtask

  initial begin
    // CCW, fractional coordinates floor toward the integer below
    vecs[0] = '{vx: {q(10), q(50), q(10) + 32'h0000_C000},
                vy: {q(40) + 32'h0000_8000, q(10), q(10)},
                vu: {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001},
                vv: {32'h5555_0003, 32'h5555_0002, 32'h5555_0001},
                vz: {8'h33, 8'h22, 8'h11}, cull: 1'b0,
                ex: {12'd10, 12'd50, 12'd10}, ey: {12'd40, 12'd10, 12'd10},
                ez: {8'h33, 8'h22, 8'h11},
                eu: {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001},
                ev: {32'h5555_0003, 32'h5555_0002, 32'h5555_0001},
                earea: 27'd1200, exmin: 12'd10, exmax: 12'd50, eymin: 12'd10, eymax: 12'd40};
    // CW: slots 1 and 2 swap, z/u/v follow
    vecs[1] = '{vx: {q(50), q(10), q(10)}, vy: {q(10), q(40), q(10)},
                vu: {32'h1111_0003, 32'h1111_0002, 32'h1111_0001},
                vv: {32'h2222_0003, 32'h2222_0002, 32'h2222_0001},
                vz: {8'h66, 8'h55, 8'h44}, cull: 1'b0,
                ex: {12'd10, 12'd50, 12'd10}, ey: {12'd40, 12'd10, 12'd10},
                ez: {8'h55, 8'h66, 8'h44},
                eu: {32'h1111_0002, 32'h1111_0003, 32'h1111_0001},
                ev: {32'h2222_0002, 32'h2222_0003, 32'h2222_0001},
                earea: 27'd1200, exmin: 12'd10, exmax: 12'd50, eymin: 12'd10, eymax: 12'd40};
    // collinear
    vecs[2] = '{vx: {q(20), q(10), q(0)}, vy: {q(20), q(10), q(0)},
                vu: '0, vv: '0, vz: '0, cull: 1'b1, ex: '0, ey: '0, ez: '0, eu: '0, ev: '0,
                earea: '0, exmin: '0, exmax: '0, eymin: '0, eymax: '0};
    // entirely right of the screen
    vecs[3] = '{vx: {q(320), q(400), q(320)}, vy: {q(50), q(0), q(0)},
                vu: '0, vv: '0, vz: '0, cull: 1'b1, ex: '0, ey: '0, ez: '0, eu: '0, ev: '0,
                earea: '0, exmin: '0, exmax: '0, eymin: '0, eymax: '0};
    // partly off-screen: x0=-19.5 -> -20, y0=-4.25 -> -5
    vecs[4] = '{vx: {q(100), q(400), q(-20) + 32'h0000_8000},
                vy: {q(300), q(-5), q(-5) + 32'h0000_C000},
                vu: {32'h0000_0C00, 32'h0000_0B00, 32'h0000_0A00},
                vv: {32'hF000_000C, 32'hF000_000B, 32'hF000_000A},
                vz: {8'hFE, 8'h80, 8'h00}, cull: 1'b0,
                ex: {12'd100, 12'd400, 12'hFEC}, ey: {12'd300, 12'hFFB, 12'hFFB},
                ez: {8'hFE, 8'h80, 8'h00},
                eu: {32'h0000_0C00, 32'h0000_0B00, 32'h0000_0A00},
                ev: {32'hF000_000C, 32'hF000_000B, 32'hF000_000A},
                earea: 27'd128100, exmin: 12'd0, exmax: 12'd319, eymin: 12'd0, eymax: 12'd239};
    // exactly screen-sized corner triangle
    vecs[5] = '{vx: {q(0), q(319), q(0)}, vy: {q(239), q(0), q(0)},
                vu: {32'd3, 32'd2, 32'd1}, vv: {32'd6, 32'd5, 32'd4},
                vz: {8'd9, 8'd8, 8'd7}, cull: 1'b0,
                ex: {12'd0, 12'd319, 12'd0}, ey: {12'd239, 12'd0, 12'd0},
                ez: {8'd9, 8'd8, 8'd7}, eu: {32'd3, 32'd2, 32'd1}, ev: {32'd6, 32'd5, 32'd4},
                earea: 27'd76241, exmin: 12'd0, exmax: 12'd319, eymin: 12'd0, eymax: 12'd239};
`ifdef CULL_BACKFACE_EN
    vecs[1].cull = 1'b1;
`endif

    i_rst = 1'b1;
    i_flush = 1'b0;
    i_tri_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_valid", o_tri_valid, 1'b0);
    check("rst_rd_en", o_fifo_rd_en, 1'b0);
    check("rst_state", o_dbg_state, ST_FETCH);
    check("rst_area", o_tri_area, 27'd0);
    check("rst_culled", o_culled_count, 16'd0);
    check("rst_bbox", {o_bbox_xmin, o_bbox_xmax, o_bbox_ymin, o_bbox_ymax}, 48'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // backpressure: hold 5 cycles with more vertices waiting, then reads resume
    push_vec(vecs[0]);
    expect_out(vecs[0], "hold_first");
    push_vec(vecs[0]);
    repeat (5) begin
      @(negedge i_clk);
      check("hold_valid", o_tri_valid, 1'b1);
      check("hold_x", o_tri_x, vecs[0].ex);
      check("hold_area", o_tri_area, vecs[0].earea);
      check("hold_rd_en", o_fifo_rd_en, 1'b0);
    end
    transfer("hold_first");
    check("resume_rd_en", o_fifo_rd_en, 1'b1);
    expect_out(vecs[0], "hold_second");
    transfer("hold_second");

    for (int i = 0; i < 6; i++) begin
      push_vec(vecs[i]);
      if (vecs[i].cull) begin
        expect_cull($sformatf("vec%0d", i));
      end else begin
        expect_out(vecs[i], $sformatf("vec%0d", i));
        transfer($sformatf("vec%0d", i));
      end
    end

    // flush with two vertices held; the new vertex waiting must not be read on the flush cycle
    push_one(vecs[4], 0);
    push_one(vecs[4], 1);
    repeat (8) @(negedge i_clk);
    check("partial_state", o_dbg_state, ST_FETCH);
    push_one(vecs[0], 0);
    i_flush = 1'b1;
    #1;
    check("flush_rd_en", o_fifo_rd_en, 1'b0);
    @(negedge i_clk);
    i_flush = 1'b0;
    push_one(vecs[0], 1);
    push_one(vecs[0], 2);
    expect_out(vecs[0], "flush");
    transfer("flush");

    // async reset while a triangle is waiting
    push_vec(vecs[5]);
    expect_out(vecs[5], "arst");
    check("arst_state_out", o_dbg_state, ST_OUT);
    #2;
    i_rst = 1'b1;
    #1;
    check("arst_valid", o_tri_valid, 1'b0);
    check("arst_state", o_dbg_state, ST_FETCH);
    check("arst_culled", o_culled_count, 16'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    check("arst_stays_idle", o_tri_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
